// File: rtl/svcs_hs_frame_tx.sv
// Serialises a 28-byte header plus n 32-bit payload words into a little-endian byte stream.
// Optional trailing XOR checksum byte when SVCS_FRAME_CSUM_EN is defined.
module svcs_hs_frame_tx #(
   parameter int unsigned MAX_PAYLOADS = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hdr_valid,
   output logic        hdr_ready,
   input  logic [63:0] hdr_trnx_type,
   input  logic [63:0] hdr_trnx_id,
   input  logic [63:0] hdr_data_type,
   input  logic [31:0] hdr_n_payloads,
   input  logic        pl_valid,
   output logic        pl_ready,
   input  logic [31:0] pl_data,
   output logic        byte_valid,
   input  logic        byte_ready,
   output logic [7:0]  byte_data,
   output logic        byte_last,
   output logic        busy,
   output logic        err_len
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_PL_LOAD,
      S_PL_SHIFT
`ifdef SVCS_FRAME_CSUM_EN
      , S_CSUM
`endif
   } state_t;

   state_t         state_q, state_d;
   logic [223:0]   hdr_q, hdr_d;
   logic [4:0]     idx_q, idx_d;
   logic [31:0]    cnt_q, cnt_d;
   logic [31:0]    word_q, word_d;
   logic [1:0]     bidx_q, bidx_d;
   logic           err_q, err_d;
   logic           run_q;
`ifdef SVCS_FRAME_CSUM_EN
   logic [7:0]     csum_q, csum_d;
`endif

   // run_q delays hdr_ready by one clock after reset release
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         hdr_q   <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         word_q  <= '0;
         bidx_q  <= '0;
         err_q   <= 1'b0;
         run_q   <= 1'b0;
`ifdef SVCS_FRAME_CSUM_EN
         csum_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         hdr_q   <= hdr_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
         bidx_q  <= bidx_d;
         err_q   <= err_d;
         run_q   <= 1'b1;
`ifdef SVCS_FRAME_CSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      hdr_d      = hdr_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      word_d     = word_q;
      bidx_d     = bidx_q;
      err_d      = 1'b0;
      hdr_ready  = 1'b0;
      pl_ready   = 1'b0;
      byte_valid = 1'b0;
      byte_data  = '0;
      byte_last  = 1'b0;
`ifdef SVCS_FRAME_CSUM_EN
      csum_d     = csum_q;
`endif
      case (state_q)
         S_IDLE: begin
            hdr_ready = run_q;
            if (hdr_valid && run_q) begin
               if (hdr_n_payloads > 32'(MAX_PAYLOADS)) begin
                  err_d = 1'b1;
               end else begin
                  hdr_d   = {hdr_n_payloads, hdr_data_type, hdr_trnx_id, hdr_trnx_type};
                  idx_d   = '0;
                  cnt_d   = hdr_n_payloads;
                  state_d = S_HDR;
`ifdef SVCS_FRAME_CSUM_EN
                  csum_d  = '0;
`endif
               end
            end
         end
         S_HDR: begin
            byte_valid = 1'b1;
            byte_data  = hdr_q[7:0];
`ifndef SVCS_FRAME_CSUM_EN
            byte_last  = (idx_q == 5'd27) && (cnt_q == 32'd0);
`endif
            if (byte_ready) begin
               hdr_d = hdr_q >> 8;
               idx_d = idx_q + 5'd1;
`ifdef SVCS_FRAME_CSUM_EN
               csum_d = csum_q ^ hdr_q[7:0];
`endif
               if (idx_q == 5'd27) begin
                  if (cnt_q == 32'd0) begin
`ifdef SVCS_FRAME_CSUM_EN
                     state_d = S_CSUM;
`else
                     state_d = S_IDLE;
`endif
                  end else begin
                     state_d = S_PL_LOAD;
                  end
               end
            end
         end
         S_PL_LOAD: begin
            pl_ready = 1'b1;
            if (pl_valid) begin
               word_d  = pl_data;
               bidx_d  = '0;
               state_d = S_PL_SHIFT;
            end
         end
         S_PL_SHIFT: begin
            byte_valid = 1'b1;
            byte_data  = word_q[7:0];
`ifndef SVCS_FRAME_CSUM_EN
            byte_last  = (bidx_q == 2'd3) && (cnt_q == 32'd1);
`endif
            if (byte_ready) begin
               word_d = word_q >> 8;
               bidx_d = bidx_q + 2'd1;
`ifdef SVCS_FRAME_CSUM_EN
               csum_d = csum_q ^ word_q[7:0];
`endif
               if (bidx_q == 2'd3) begin
                  cnt_d = cnt_q - 32'd1;
                  if (cnt_q == 32'd1) begin
`ifdef SVCS_FRAME_CSUM_EN
                     state_d = S_CSUM;
`else
                     state_d = S_IDLE;
`endif
                  end else begin
                     state_d = S_PL_LOAD;
                  end
               end
            end
         end
`ifdef SVCS_FRAME_CSUM_EN
         S_CSUM: begin
            byte_valid = 1'b1;
            byte_data  = csum_q;
            byte_last  = 1'b1;
            if (byte_ready) state_d = S_IDLE;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   assign busy    = (state_q != S_IDLE);
   assign err_len = err_q;

endmodule

// File: tb/tb_svcs_hs_frame_tx.sv
// Randomised bench for svcs_hs_frame_tx: expected byte streams come from a field-level frame model.
// Also covers the SVCS_FRAME_CSUM_EN build when that macro is defined.
module tb_svcs_hs_frame_tx;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        hdr_valid = 1'b0;
   logic        hdr_ready;
   logic [63:0] hdr_trnx_type = '0;
   logic [63:0] hdr_trnx_id = '0;
   logic [63:0] hdr_data_type = '0;
   logic [31:0] hdr_n_payloads = '0;
   logic        pl_valid = 1'b0;
   logic        pl_ready;
   logic [31:0] pl_data = '0;
   logic        byte_valid;
   logic        byte_ready = 1'b0;
   logic [7:0]  byte_data;
   logic        byte_last;
   logic        busy;
   logic        err_len;

   svcs_hs_frame_tx #(.MAX_PAYLOADS(1024)) dut (
      .clk(clk), .rst(rst),
      .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
      .hdr_trnx_type(hdr_trnx_type), .hdr_trnx_id(hdr_trnx_id),
      .hdr_data_type(hdr_data_type), .hdr_n_payloads(hdr_n_payloads),
      .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_data(pl_data),
      .byte_valid(byte_valid), .byte_ready(byte_ready),
      .byte_data(byte_data), .byte_last(byte_last),
      .busy(busy), .err_len(err_len)
   );

   always #5 clk = ~clk;

   int          errors = 0;
   int          checks = 0;
   logic [8:0]  got[$];
   logic [7:0]  exp_q[$];
   logic [31:0] words[$];
   logic [31:0] pl_src[$];
   int          pl_hs = 0;
   int          err_pulses = 0;
   bit          bv_seen = 0;
   bit          pl_take = 0;
   bit          rand_rdy = 0;
   bit          rand_plv = 0;
   int          stall_idx = -1;
   int          stall_left = 0;
   bit          stall_done = 0;

   task automatic check_eq(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
      checks++;
      if (got_v !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
      end
   endtask

   // Monitor: everything visible at the negedge is what the next posedge will consume
   always @(negedge clk) begin
      if (byte_valid && byte_ready) got.push_back({byte_last, byte_data});
      if (byte_valid) bv_seen = 1;
      if (err_len) err_pulses++;
      if (pl_valid && pl_ready) begin
         pl_hs++;
         pl_take = 1;
      end
      if (byte_valid && !byte_ready && stall_idx >= 0 && got.size() == stall_idx
          && exp_q.size() > stall_idx)
         check_eq("stall_data", {56'd0, byte_data}, {56'd0, exp_q[stall_idx]});
   end

   always @(posedge clk) begin
      #1;
      if (pl_take) begin
         if (pl_src.size() > 0) void'(pl_src.pop_front());
         pl_take = 0;
      end
      if (pl_src.size() > 0) begin
         pl_valid = rand_plv ? ($urandom_range(0, 2) != 0) : 1'b1;
         pl_data  = pl_src[0];
      end else begin
         pl_valid = 1'b0;
         pl_data  = '0;
      end
      if (stall_idx >= 0 && !stall_done && got.size() == stall_idx) begin
         stall_left = 5;
         stall_done = 1;
      end
      if (stall_left > 0) begin
         byte_ready = 1'b0;
         stall_left--;
      end else begin
         byte_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
   end

   task automatic push_le(input logic [63:0] v, input int nb);
      for (int i = 0; i < nb; i++) exp_q.push_back(8'(v >> (8 * i)));
   endtask

   task automatic build_model(input logic [63:0] tt, id, dt, input logic [31:0] n);
      logic [7:0] x;
      exp_q.delete();
      push_le(tt, 8);
      push_le(id, 8);
      push_le(dt, 8);
      push_le({32'd0, n}, 4);
      foreach (words[i]) push_le({32'd0, words[i]}, 4);
`ifdef SVCS_FRAME_CSUM_EN
      x = '0;
      foreach (exp_q[i]) x ^= exp_q[i];
      exp_q.push_back(x);
`else
      x = '0;
`endif
   endtask

   task automatic send_hdr(input logic [63:0] tt, id, dt, input logic [31:0] n, input string tag);
      int c;
      @(posedge clk);
      #1;
      hdr_trnx_type  = tt;
      hdr_trnx_id    = id;
      hdr_data_type  = dt;
      hdr_n_payloads = n;
      hdr_valid      = 1'b1;
      c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (!hdr_ready && c < 100);
      if (c >= 100) check_eq({tag, " hdr_accept_timeout"}, 64'd0, 64'd1);
      @(posedge clk);
      #1;
      hdr_valid = 1'b0;
   endtask

   task automatic run_frame(input logic [63:0] tt, id, dt, input string tag);
      logic [31:0] n;
      int budget, cyc, nl;
      n = 32'(words.size());
      build_model(tt, id, dt, n);
      got.delete();
      pl_hs = 0;
      err_pulses = 0;
      stall_done = 0;
      pl_src = words;
      send_hdr(tt, id, dt, n, tag);
      budget = 20 * exp_q.size() + 200;
      cyc = 0;
      while (!(got.size() > 0 && got[$][8]) && cyc < budget) begin
         @(negedge clk);
         cyc++;
      end
      check_eq({tag, " completed"}, {63'd0, cyc < budget}, 64'd1);
      repeat (2) @(negedge clk);
      check_eq({tag, " length"}, 64'(got.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
         check_eq($sformatf("%s byte%0d", tag, i), {56'd0, got[i][7:0]}, {56'd0, exp_q[i]});
      nl = 0;
      foreach (got[i]) if (got[i][8]) nl++;
      check_eq({tag, " last_count"}, 64'(nl), 64'd1);
      if (got.size() > 0) check_eq({tag, " last_on_final"}, {63'd0, got[$][8]}, 64'd1);
      check_eq({tag, " pl_handshakes"}, 64'(pl_hs), {32'd0, n});
      check_eq({tag, " err_len"}, 64'(err_pulses), 64'd0);
      check_eq({tag, " busy_after"}, {63'd0, busy}, 64'd0);
      check_eq({tag, " hdr_ready_after"}, {63'd0, hdr_ready}, 64'd1);
   endtask

   task automatic check_outputs_zero(input string tag);
      check_eq({tag, " hdr_ready"}, {63'd0, hdr_ready}, 64'd0);
      check_eq({tag, " pl_ready"}, {63'd0, pl_ready}, 64'd0);
      check_eq({tag, " byte_valid"}, {63'd0, byte_valid}, 64'd0);
      check_eq({tag, " byte_data"}, {56'd0, byte_data}, 64'd0);
      check_eq({tag, " byte_last"}, {63'd0, byte_last}, 64'd0);
      check_eq({tag, " busy"}, {63'd0, busy}, 64'd0);
      check_eq({tag, " err_len"}, {63'd0, err_len}, 64'd0);
   endtask

   task automatic release_reset(input string tag);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_eq({tag, " hdr_ready_before_clk"}, {63'd0, hdr_ready}, 64'd0);
      @(posedge clk);
      #1;
      check_eq({tag, " hdr_ready_after_clk"}, {63'd0, hdr_ready}, 64'd1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int cyc, nl;
      logic [63:0] tt, id, dt;

      #3;
      check_outputs_zero("reset");
      repeat (2) @(posedge clk);
      release_reset("reset_release");

      words.delete();
      run_frame(64'h1122334455667788, 64'd1, 64'd0, "basic_n0");
      if (got.size() > 8) begin
         check_eq("basic_n0 first_byte", {56'd0, got[0][7:0]}, 64'h88);
         check_eq("basic_n0 byte8", {56'd0, got[8][7:0]}, 64'h01);
      end

      words = '{32'hDEADBEEF, 32'h01020304};
      run_frame(64'h1122334455667788, 64'd1, 64'd0, "n2");

      stall_idx = 10;
      words.delete();
      run_frame({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, "stall");
      stall_idx = -1;

      for (int k = 0; k < 6; k++) begin
         rand_rdy = 1;
         rand_plv = 1;
         words.delete();
         for (int j = 0; j < int'($urandom_range(0, 5)); j++) words.push_back($urandom);
         run_frame({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                   $sformatf("rand%0d", k));
      end
      rand_rdy = 0;
      rand_plv = 0;

      err_pulses = 0;
      bv_seen = 0;
      send_hdr(64'd5, 64'd6, 64'd7, 32'd1025, "oversize");
      @(negedge clk);
      check_eq("oversize err_len_pulse", {63'd0, err_len}, 64'd1);
      check_eq("oversize hdr_ready_next", {63'd0, hdr_ready}, 64'd1);
      repeat (3) @(negedge clk);
      check_eq("oversize err_len_count", 64'(err_pulses), 64'd1);
      check_eq("oversize no_bytes", {63'd0, bv_seen}, 64'd0);
      check_eq("oversize busy", {63'd0, busy}, 64'd0);

      words.delete();
      for (int j = 0; j < 1024; j++) words.push_back($urandom);
      run_frame({$urandom, $urandom}, 64'd2, 64'd3, "n1024");

      words = '{$urandom, $urandom};
      got.delete();
      pl_src = words;
      build_model(64'd9, 64'd8, 64'd7, 32'd2);
      send_hdr(64'd9, 64'd8, 64'd7, 32'd2, "midrst");
      cyc = 0;
      while (cyc < 300) begin
         @(posedge clk);
         #2;
         if (got.size() == 30 && byte_valid) break;
         cyc++;
      end
      check_eq("midrst reached_pl_byte2", {63'd0, cyc < 300}, 64'd1);
      rst = 1'b1;
      #1;
      check_outputs_zero("midrst");
      nl = 0;
      foreach (got[i]) if (got[i][8]) nl++;
      check_eq("midrst no_last", 64'(nl), 64'd0);
      pl_src.delete();
      @(posedge clk);
      release_reset("midrst_release");
      pl_src.delete();
      words.delete();
      run_frame(64'h0123456789ABCDEF, 64'd4, 64'd5, "post_rst_n0");

`ifdef SVCS_FRAME_CSUM_EN
      words = '{32'h000000FF};
      run_frame(64'd0, 64'd0, 64'd0, "csum");
      check_eq("csum total", 64'(got.size()), 64'd33);
      if (got.size() > 0) check_eq("csum final", {56'd0, got[$][7:0]}, 64'hFE);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/svcs_hs_frame_tx.md
SVCS_HS_FRAME_TX -- requirements
Module: svcs_hs_frame_tx

Interface
REQ-001 SHALL have parameter MAX_PAYLOADS, default 1024, the maximum payload word count accepted per frame (4096-byte frame payload limit).
REQ-002 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port hdr_valid  input  1  header offered.
REQ-005 SHALL have port hdr_ready  output  1  header accepted when high with hdr_valid.
REQ-006 SHALL have port hdr_trnx_type  input  64  transaction type (IEEE-754 double bit pattern).
REQ-007 SHALL have port hdr_trnx_id  input  64  transaction id (double bit pattern).
REQ-008 SHALL have port hdr_data_type  input  64  data type hash (double bit pattern).
REQ-009 SHALL have port hdr_n_payloads  input  32  payload word count, unsigned.
REQ-010 SHALL have ports pl_valid input 1, pl_ready output 1, pl_data input 32: payload word handshake.
REQ-011 SHALL have ports byte_valid output 1, byte_ready input 1, byte_data output 8, byte_last output 1: outgoing socket byte stream.
REQ-012 SHALL have ports busy output 1 (frame in progress) and err_len output 1 (oversize pulse).

Function
REQ-013 Frame layout: trnx_type, trnx_id, data_type (8 bytes each), n_payloads (4 bytes), then n_payloads words of 4 bytes; every field little-endian, LSB first.
REQ-014 FSM states: IDLE, HDR, PL_LOAD, PL_SHIFT (plus CSUM when REQ-027 is enabled).
REQ-015 IDLE: hdr_ready=1, busy=0; on hdr_valid&&hdr_ready, capture all header fields into a 224-bit shift register, go to HDR.
REQ-016 Oversize: if captured hdr_n_payloads > MAX_PAYLOADS, err_len=1 for exactly one cycle, no byte emitted, return to IDLE; hdr_ready high again the next cycle.
REQ-017 HDR: byte_valid=1 from the cycle after header acceptance; 5-bit index 0..27; advance only on byte_valid&&byte_ready.
REQ-018 byte_data and byte_last SHALL hold stable while byte_valid=1 and byte_ready=0; no byte is skipped or repeated.
REQ-019 On handshake of header byte 27: n_payloads==0 -> byte_last=1 on that byte, go to IDLE; else load remaining-word counter with n_payloads, go to PL_LOAD.
REQ-020 PL_LOAD: pl_ready=1, byte_valid=0; on pl_valid handshake, capture pl_data, go to PL_SHIFT (one bubble cycle per word is intended).
REQ-021 PL_SHIFT: emit 4 bytes; on handshake of byte 3, decrement counter; counter reaches 0 -> byte_last on that byte, go to IDLE; else go to PL_LOAD.
REQ-022 pl_ready SHALL be 0 outside PL_LOAD; hdr_ready SHALL be 0 outside IDLE; busy=1 in every state except IDLE.
REQ-023 Frame length: 28 + 4*n_payloads bytes; byte_last asserted on exactly one byte per frame.

Reset
REQ-024 rst=1 SHALL immediately force state IDLE and outputs hdr_ready=0, pl_ready=0, byte_valid=0, byte_data=0, byte_last=0, busy=0, err_len=0; hdr_ready rises the first clock after rst deasserts.
REQ-025 Reset mid-frame SHALL abandon the frame without emitting byte_last; counters and shift register are cleared.
REQ-026 After reset the first accepted header SHALL produce a complete frame starting at header byte 0.

Configuration
REQ-027 Macro SVCS_FRAME_CSUM_EN defined: after the last payload byte (or header byte 27 when n_payloads==0), state CSUM emits one byte = XOR of all preceding frame bytes; byte_last moves to this byte; frame length +1.
REQ-028 SVCS_FRAME_CSUM_EN undefined: no CSUM state, no checksum logic, frame per REQ-023.

Verification
REQ-029 Header type=0x1122334455667788, id=1, data_type=0, n=0, byte_ready=1 -> 28 bytes, first 0x88, byte 8 = 0x01, byte_last on byte 28 only.
REQ-030 n=2, payloads 0xDEADBEEF, 0x01020304 -> bytes 29..36 = EF BE AD DE 04 03 02 01, byte_last on byte 36, pl_ready pulses exactly twice.
REQ-031 byte_ready held 0 for 5 cycles at header byte 10 -> byte_data unchanged across stall, total byte count still 28.
REQ-032 n=1025 -> err_len high one cycle, byte_valid never asserts, hdr_ready=1 next cycle; n=1024 accepted normally.
REQ-033 rst pulsed during payload byte 2 -> all outputs 0 in same cycle, no byte_last; subsequent n=0 header yields clean 28-byte frame.
REQ-034 With SVCS_FRAME_CSUM_EN, all-zero header fields except n=1, payload 0x000000FF -> 33 bytes, final byte 0xFE with byte_last.
